// File: rtl/pop_sequencer.sv
// pop_sequencer: multi-channel pulse sequencer driven by a free-running
// period counter. Each channel emits a pulse over [start, stop) of the
// period, for a programmed number of periods or continuously.
// Optional build macro: POP_SHADOW_EN -- config writes go to a shadow set
// that is copied to the active set at each period wrap and while idle/done.
module pop_sequencer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                clock_2_5M,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [WIDTH-1:0]    cycles,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pulse,
  output logic                period_strobe,
  output logic                busy,
  output logic                done
);

  // 10 ms at 2.5 MHz
  localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(25000);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [WIDTH-1:0]               count_q, count_d;
  logic [WIDTH-1:0]               ncyc_q, ncyc_d;
  logic [WIDTH-1:0]               cycles_q, cycles_d;
  logic [CHANNELS-1:0]            pulse_q, pulse_d;
  logic                           strobe_q, strobe_d;
  logic                           busy_q, done_q;

  // Active configuration (drives the compares)
  logic [WIDTH-1:0]               period_q, period_d;
  logic [CHANNELS-1:0][WIDTH-1:0] start_q, start_d;
  logic [CHANNELS-1:0][WIDTH-1:0] stop_q, stop_d;

`ifdef POP_SHADOW_EN
  // Host-visible staging copy of the configuration
  logic [WIDTH-1:0]               sh_period_q, sh_period_d;
  logic [CHANNELS-1:0][WIDTH-1:0] sh_start_q, sh_start_d;
  logic [CHANNELS-1:0][WIDTH-1:0] sh_stop_q, sh_stop_d;
`endif

  // Register set after applying this cycle's host write
  logic [WIDTH-1:0]               wr_period;
  logic [CHANNELS-1:0][WIDTH-1:0] wr_start;
  logic [CHANNELS-1:0][WIDTH-1:0] wr_stop;

  logic [WIDTH-1:0]               eff_period;
  logic                           wrap;
  logic                           last_period;
  logic [CHANNELS-1:0]            window;

  // Periods of 0 or 1 cannot wrap sensibly; run them as 2
  assign eff_period = (period_q < WIDTH'(2)) ? WIDTH'(2) : period_q;

  // >= so a period shrunk below the current count still wraps at once
  assign wrap = (state_q == S_RUN) && (count_q >= (eff_period - WIDTH'(1)));

  assign last_period = (cycles_q != '0) && (ncyc_q == (cycles_q - WIDTH'(1)));

  // Per-channel window test on the current count
  always_comb begin
    window = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      window[i] = (start_q[i] <= count_q) && (count_q < stop_q[i]);
    end
  end

  // Host write decode; addresses beyond the last stop register match nothing
  always_comb begin
`ifdef POP_SHADOW_EN
    wr_period = sh_period_q;
    wr_start  = sh_start_q;
    wr_stop   = sh_stop_q;
`else
    wr_period = period_q;
    wr_start  = start_q;
    wr_stop   = stop_q;
`endif
    if (wr_en) begin
      if (wr_addr == '0) begin
        wr_period = wr_data;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_addr == ADDR_W'(2 * i + 1)) begin
          wr_start[i] = wr_data;
        end
        if (wr_addr == ADDR_W'(2 * i + 2)) begin
          wr_stop[i] = wr_data;
        end
      end
    end
  end

  // Next value of the active (and shadow) configuration
  always_comb begin
`ifdef POP_SHADOW_EN
    sh_period_d = wr_period;
    sh_start_d  = wr_start;
    sh_stop_d   = wr_stop;
    period_d    = period_q;
    start_d     = start_q;
    stop_d      = stop_q;
    // Old shadow contents move over; a write on this same edge waits a period
    if (wrap || (state_q != S_RUN)) begin
      period_d = sh_period_q;
      start_d  = sh_start_q;
      stop_d   = sh_stop_q;
    end
`else
    period_d = wr_period;
    start_d  = wr_start;
    stop_d   = wr_stop;
`endif
  end

  // Configuration registers
  always_ff @(posedge clock_2_5M or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= RST_PERIOD;
      start_q  <= '0;
      stop_q   <= '0;
`ifdef POP_SHADOW_EN
      sh_period_q <= RST_PERIOD;
      sh_start_q  <= '0;
      sh_stop_q   <= '0;
`endif
    end else begin
      period_q <= period_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
`ifdef POP_SHADOW_EN
      sh_period_q <= sh_period_d;
      sh_start_q  <= sh_start_d;
      sh_stop_q   <= sh_stop_d;
`endif
    end
  end

  // Sequencer next-state, counters and output decode
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ncyc_d   = ncyc_q;
    cycles_d = cycles_q;
    pulse_d  = '0;
    strobe_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        ncyc_d  = '0;
        if (enable) begin
          state_d  = S_RUN;
          cycles_d = cycles;
        end
      end
      S_RUN: begin
        if (!enable) begin
          // Abort: no partial-period completion
          state_d = S_IDLE;
          count_d = '0;
          ncyc_d  = '0;
        end else begin
          strobe_d = (count_q == '0);
          pulse_d  = window;
          if (wrap) begin
            count_d = '0;
            ncyc_d  = ncyc_q + WIDTH'(1);
            if (last_period) begin
              // Outputs are quiet for the whole of DONE
              state_d = S_DONE;
              ncyc_d  = '0;
              pulse_d = '0;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        count_d = '0;
        ncyc_d  = '0;
        if (!enable) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
        ncyc_d  = '0;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clock_2_5M or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      ncyc_q   <= '0;
      cycles_q <= '0;
      pulse_q  <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ncyc_q   <= ncyc_d;
      cycles_q <= cycles_d;
      pulse_q  <= pulse_d;
      strobe_q <= strobe_d;
      busy_q   <= (state_d == S_RUN);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign pulse         = pulse_q;
  assign period_strobe = strobe_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_pop_sequencer.sv
// Self-checking bench for pop_sequencer: table-driven scenarios with a
// per-cycle expectation queue, plus hand sequences for mid-run writes,
// abort and asynchronous reset.
`timescale 1ns/1ps
module tb_pop_sequencer;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CH     = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned OBS_W  = CH + 3;

  typedef logic [OBS_W-1:0] obs_t;   // {pulse, period_strobe, busy, done}

  typedef struct packed {
    logic [WIDTH-1:0]          period;
    logic [CH-1:0][WIDTH-1:0]  start;
    logic [CH-1:0][WIDTH-1:0]  stop;
    logic [WIDTH-1:0]          cyc;
    logic [WIDTH-1:0]          run_len;
    logic [CH-1:0][WIDTH-1:0]  exp_hi;
    logic [WIDTH-1:0]          exp_strobes;
  } scen_t;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [WIDTH-1:0]  cycles;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [CH-1:0]     pulse;
  logic              period_strobe;
  logic              busy;
  logic              done;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];
  scen_t tbl [4];

  // Spec-level model state for the running configuration
  int m_period;
  int m_start [CH];
  int m_stop  [CH];
  int m_total;      // RUN cycles in a finite run, 0 = continuous

  pop_sequencer #(.WIDTH(WIDTH), .CHANNELS(CH), .ADDR_W(ADDR_W)) dut (
    .clock_2_5M    (clk),
    .reset_n       (rst_n),
    .enable        (enable),
    .cycles        (cycles),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .pulse         (pulse),
    .period_strobe (period_strobe),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs one cycle after RUN cycle k
  function automatic obs_t model(input int k);
    int eff;
    int ph;
    logic [CH-1:0] p;
    logic s, b, d;
    bit last;
    eff  = (m_period < 2) ? 2 : m_period;
    ph   = k % eff;
    last = (m_total != 0) && (k == m_total - 1);
    for (int i = 0; i < CH; i++) p[i] = (m_start[i] <= ph) && (ph < m_stop[i]) && !last;
    s = (ph == 0);
    b = (m_total == 0) || (k + 1 < m_total);
    d = !b;
    return {p, s, b, d};
  endfunction

  task automatic check(input string name);
    obs_t act, e;
    act = {pulse, period_strobe, busy, done};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: nothing expected, actual %b", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: actual {pulse,strobe,busy,done}=%b required %b", name, $time, act, e);
      end
    end
  endtask

  task automatic step(input string name, input obs_t e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    check(name);
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [WIDTH-1:0] c);
    cycles = c; enable = 1'b1;
    step("start", {{CH{1'b0}}, 3'b010});
  endtask

  task automatic check_count(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Program a table entry into the DUT and the model
  task automatic load_cfg(input int s);
    int eff;
    cfg_write(ADDR_W'(15), WIDTH'(3));      // out of range, must be ignored
    cfg_write('0, tbl[s].period);
    for (int i = 0; i < CH; i++) begin
      cfg_write(ADDR_W'(2 * i + 1), tbl[s].start[i]);
      cfg_write(ADDR_W'(2 * i + 2), tbl[s].stop[i]);
      m_start[i] = int'(tbl[s].start[i]);
      m_stop[i]  = int'(tbl[s].stop[i]);
    end
    m_period = int'(tbl[s].period);
    eff      = (m_period < 2) ? 2 : m_period;
    m_total  = int'(tbl[s].cyc) * eff;
  endtask

  initial begin
    int hi [CH];
    int strobes;

    // {period, start ch3..ch0, stop ch3..ch0, cycles, run_len, highs ch3..ch0, strobes}
    tbl[0] = '{16'd10, {16'd0, 16'd0, 16'd0, 16'd2}, {16'd0, 16'd0, 16'd0, 16'd5},
               16'd3, 16'd30, {16'd0, 16'd0, 16'd0, 16'd9}, 16'd3};
    tbl[1] = '{16'd8, {16'd0, 16'd0, 16'd0, 16'd0}, {16'd0, 16'd0, 16'd8, 16'd0},
               16'd0, 16'd40, {16'd0, 16'd0, 16'd40, 16'd0}, 16'd5};
    tbl[2] = '{16'd10, {16'd4, 16'd6, 16'd0, 16'd0}, {16'd20, 16'd3, 16'd0, 16'd0},
               16'd0, 16'd30, {16'd18, 16'd0, 16'd0, 16'd0}, 16'd3};
    tbl[3] = '{16'd0, {16'd0, 16'd0, 16'd0, 16'd0}, {16'd0, 16'd0, 16'd0, 16'd1},
               16'd4, 16'd8, {16'd0, 16'd0, 16'd0, 16'd4}, 16'd4};

    rst_n = 1'b1; enable = 1'b0; cycles = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    check("reset_state");
    rst_n = 1'b1;
    step("idle_after_reset", '0);

    // Table-driven scenarios
    for (int s = 0; s < 4; s++) begin
      load_cfg(s);
      start_run(tbl[s].cyc);
      strobes = 0;
      for (int i = 0; i < CH; i++) hi[i] = 0;
      for (int k = 0; k < int'(tbl[s].run_len); k++) begin
        step($sformatf("scen%0d_k%0d", s, k), model(k));
        for (int i = 0; i < CH; i++) if (pulse[i]) hi[i]++;
        if (period_strobe) strobes++;
      end
      for (int i = 0; i < CH; i++)
        check_count($sformatf("scen%0d_highs_ch%0d", s, i), hi[i], int'(tbl[s].exp_hi[i]));
      check_count($sformatf("scen%0d_strobes", s), strobes, int'(tbl[s].exp_strobes));
      if (tbl[s].cyc != '0) begin
        step($sformatf("scen%0d_done_hold", s), {{CH{1'b0}}, 3'b001});
        enable = 1'b0;
        step($sformatf("scen%0d_done_exit", s), '0);
      end else begin
        enable = 1'b0;
        step($sformatf("scen%0d_abort", s), '0);
      end
    end

    // Mid-period stop write at count 3, and a start write on a wrap edge
    load_cfg(0);
    m_total = 0;
    start_run('0);
    for (int k = 0; k < 40; k++) begin
`ifdef POP_SHADOW_EN
      if (k == 10) m_stop[0] = 7;
      if (k == 30) m_start[0] = 0;
`else
      if (k == 4)  m_stop[0] = 7;
      if (k == 20) m_start[0] = 0;
`endif
      if (k == 3)  begin wr_en = 1'b1; wr_addr = ADDR_W'(2); wr_data = WIDTH'(7); end
      if (k == 19) begin wr_en = 1'b1; wr_addr = ADDR_W'(1); wr_data = WIDTH'(0); end
      step($sformatf("midwrite_k%0d", k), model(k));
      wr_en = 1'b0;
    end
    enable = 1'b0;
    step("midwrite_abort", '0);

    // Abort with enable low at count 5
    start_run('0);
    for (int k = 0; k < 5; k++) step($sformatf("abort5_k%0d", k), model(k));
    enable = 1'b0;
    step("abort5_drop", '0);
    step("abort5_idle", '0);

    // Reset asserted mid-run clears outputs immediately
    start_run('0);
    for (int k = 0; k < 12; k++) step($sformatf("prereset_k%0d", k), model(k));
    rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    check("reset_async");
    enable = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back('0);
    check("reset_held");
    rst_n = 1'b1;

    // Reset restored period 25000 and zero windows
    m_period = 25000;
    for (int i = 0; i < CH; i++) begin m_start[i] = 0; m_stop[i] = 0; end
    m_total = 0;
    start_run('0);
    for (int k = 0; k <= 25000; k++) step($sformatf("rstcfg_k%0d", k), model(k));
    enable = 1'b0;
    step("rstcfg_abort", '0);

    check_count("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
